// File: rtl/gb_pkg.sv
// Shared Game Boy system constants and types used across the memory-side blocks.
package gb_pkg;

  localparam logic [15:0] ADDR_DMA  = 16'hFF46;
  localparam logic [15:0] ADDR_OAM  = 16'hFE00;
  localparam logic [15:0] ECHO_BASE = 16'hE000;
  localparam int unsigned OAM_LEN   = 160;

  typedef enum logic [1:0] {
    IDLE,
    START,
    READ,
    WRITE
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: on a write to the trigger register, copies XFER_LEN bytes
// from {src_hi, 8'h00} to OAM, owning the memory bus while busy is high.
module oam_dma
  import gb_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 16,
  parameter int unsigned            DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]  REG_ADDR   = ADDR_DMA,
  parameter logic [ADDR_WIDTH-1:0]  OAM_BASE   = ADDR_OAM,
  parameter int unsigned            XFER_LEN   = OAM_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_wr_en,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [DATA_WIDTH-1:0] ECHO_HI  = DATA_WIDTH'(ECHO_BASE >> 8);
  localparam logic [DATA_WIDTH-1:0] ECHO_OFS = DATA_WIDTH'(8'h20);

  dma_state_t            state;
  logic [7:0]            idx;
  logic [DATA_WIDTH-1:0] byte_q;
  logic [DATA_WIDTH-1:0] src_hi;
  logic [DATA_WIDTH-1:0] dma_reg;
  logic                  trig;
  logic                  last;

  assign trig      = cpu_wr_en && (cpu_addr == REG_ADDR);
  assign last      = (idx == 8'(XFER_LEN - 1));
  assign cpu_rdata = dma_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      byte_q  <= '0;
      src_hi  <= '0;
      dma_reg <= '1;
    end else if (trig) begin
      // A retrigger overrides any state; a WRITE on this edge still lands in memory.
      dma_reg <= cpu_wdata;
      src_hi  <= (cpu_wdata >= ECHO_HI) ? cpu_wdata - ECHO_OFS : cpu_wdata;
      idx     <= '0;
      state   <= START;
    end else begin
      case (state)
        START: begin
          idx   <= '0;
          state <= READ;
        end
        READ: begin
          byte_q <= mem_rdata;
          state  <= WRITE;
        end
        WRITE: begin
          if (last) begin
            state <= IDLE;
          end else begin
            idx   <= idx + 8'd1;
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    case (state)
      READ: begin
        mem_addr  = ADDR_WIDTH'({src_hi, idx});
        mem_rd_en = 1'b1;
      end
      WRITE: begin
        mem_addr  = OAM_BASE + ADDR_WIDTH'(idx);
        mem_wdata = byte_q;
        mem_wr_en = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: memory model with function-defined source contents and an
// OAM array, checked cycle by cycle against an arithmetic transfer schedule.
module tb_oam_dma;
  import gb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_wr_en = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [7:0]  mem_rdata;

  int          checks = 0;
  int          errors = 0;
  int          stray = 0;
  logic [15:0] seed = '0;
  logic [7:0]  oam [0:159];

  localparam int XFER_CYC = 2 * int'(OAM_LEN) + 1;

  oam_dma dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wr_en (cpu_wr_en),
    .cpu_rdata (cpu_rdata),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Source memory contents: seed 0 gives the i ^ 8'h5A pattern, otherwise a hash.
  function automatic logic [7:0] src_byte(input logic [15:0] a, input logic [15:0] s);
    logic [31:0] h;
    if (s == 16'h0) return a[7:0] ^ 8'h5A;
    h = ({16'h0, a ^ s} * 32'd40503) >> 8;
    return h[7:0];
  endfunction

  assign mem_rdata = src_byte(mem_addr, seed);

  always @(posedge clk) begin
    if (mem_wr_en) begin
      if (mem_addr >= 16'hFE00 && mem_addr < 16'hFEA0)
        oam[int'(mem_addr - 16'hFE00)] <= mem_wdata;
      else
        stray <= stray + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] clamp(input logic [7:0] v);
    return (v >= 8'hE0) ? v - 8'h20 : v;
  endfunction

  function automatic logic [26:0] obs_bus();
    return {busy, mem_rd_en, mem_wr_en, mem_addr, mem_wr_en ? mem_wdata : 8'h00};
  endfunction

  // Expected {busy, rd, wr, addr, wdata} k cycles after the trigger edge.
  function automatic logic [26:0] exp_bus(input logic [7:0] val, input int k);
    logic [7:0] src;
    logic [7:0] i;
    src = clamp(val);
    if (k == 0) return {3'b100, 24'h0};
    if (k >= XFER_CYC) return '0;
    if (k % 2 == 1) begin
      i = 8'((k - 1) / 2);
      return {3'b110, src, i, 8'h00};
    end
    i = 8'(k / 2 - 1);
    return {3'b101, 16'hFE00 + {8'h00, i}, src_byte({src, i}, seed)};
  endfunction

  task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wr_en = 1'b1;
    @(negedge clk);
    cpu_wr_en = 1'b0;
    cpu_addr  = '0;
  endtask

  task automatic follow(input logic [7:0] val, input int ncyc, input bit retrig,
                        input logic [7:0] nval, inout int busy_n);
    for (int k = 0; k < ncyc; k++) begin
      check("bus", 32'(obs_bus()), 32'(exp_bus(val, k)));
      if (busy) busy_n++;
      if (retrig && k == ncyc - 1) begin
        cpu_addr  = ADDR_DMA;
        cpu_wdata = nval;
        cpu_wr_en = 1'b1;
      end
      @(negedge clk);
      cpu_wr_en = 1'b0;
      cpu_addr  = '0;
    end
  endtask

  task automatic check_oam(input logic [7:0] val);
    logic [7:0] src;
    src = clamp(val);
    for (int i = 0; i < 160; i++)
      check("oam", 32'(oam[i]), 32'(src_byte({src, 8'(i)}, seed)));
  endtask

  task automatic run_full(input logic [7:0] val, input logic [15:0] s);
    int n;
    n = 0;
    seed = s;
    write_reg(ADDR_DMA, val);
    check("rdata", 32'(cpu_rdata), 32'(val));
    follow(val, XFER_CYC, 1'b0, 8'h00, n);
    check("idle_after", 32'(obs_bus()), 32'(27'h0));
    check("busy_len", 32'(n), 32'(XFER_CYC));
    check_oam(val);
  endtask

  task automatic run_retrig(input logic [7:0] v1, input logic [7:0] v2,
                            input int at, input logic [15:0] s);
    int n;
    n = 0;
    seed = s;
    write_reg(ADDR_DMA, v1);
    follow(v1, at, 1'b1, v2, n);
    check("rdata_retrig", 32'(cpu_rdata), 32'(v2));
    follow(v2, XFER_CYC, 1'b0, 8'h00, n);
    check("idle_retrig", 32'(obs_bus()), 32'(27'h0));
    check("busy_len_retrig", 32'(n), 32'(at + XFER_CYC));
    check_oam(v2);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] v2;
    int         n;

    #1 rst_n = 1'b0;
    #2;
    check("reset_bus", 32'(obs_bus()), 32'(27'h0));
    check("reset_rdata", 32'(cpu_rdata), 32'(8'hFF));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_full(8'hC1, 16'h0);
    run_full(8'hE2, 16'h3A7C);
    run_retrig(8'hC1, 8'hD0, 50, 16'h1234);

    // Mid-transfer reset
    n = 0;
    seed = 16'hBEEF;
    write_reg(ADDR_DMA, 8'hC5);
    follow(8'hC5, 100, 1'b0, 8'h00, n);
    rst_n = 1'b0;
    #1;
    check("midreset_bus", 32'(obs_bus()), 32'(27'h0));
    check("midreset_rdata", 32'(cpu_rdata), 32'(8'hFF));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("post_reset_idle", 32'(obs_bus()), 32'(27'h0));
    end
    check("post_reset_rdata", 32'(cpu_rdata), 32'(8'hFF));

    // Other register address must not trigger
    write_reg(16'hFF47, 8'h80);
    for (int k = 0; k < 10; k++) begin
      check("ff47_idle", 32'(obs_bus()), 32'(27'h0));
      @(negedge clk);
    end
    check("ff47_rdata", 32'(cpu_rdata), 32'(8'hFF));

    repeat (3) begin
      v = 8'($urandom_range(8'hC0, 8'hFF));
      run_full(v, 16'($urandom_range(1, 65535)));
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    repeat (2) begin
      v  = 8'($urandom_range(8'hC0, 8'hFF));
      v2 = 8'($urandom_range(8'hC0, 8'hFF));
      run_retrig(v, v2, $urandom_range(2, 320), 16'($urandom_range(1, 65535)));
    end

    check("stray_writes", 32'(stray), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
